// File: rtl/relu_maxpool_stage_pkg.sv
// Shared types and helpers for the ReLU + width max-pool stage.
package relu_maxpool_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int POOL_FACTOR = 2;
  localparam int RELU_MAX_W  = 64;

  // Callers sign-extend into RELU_MAX_W bits and slice the result back.
  function automatic logic [RELU_MAX_W-1:0] relu(
    input logic [RELU_MAX_W-1:0] x
  );
    return x[RELU_MAX_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_maxpool_stage_relu_max_unit.sv
// Combinational ReLU of the incoming sample plus max against the stored pair.
module relu_max_unit
  import relu_maxpool_stage_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic [BW-1:0] i_pair,
  input  logic [BW-1:0] i_data,
  output logic [BW-1:0] o_relu,
  output logic [BW-1:0] o_max
);

  logic [RELU_MAX_W-1:0] w_ext;
  logic [RELU_MAX_W-1:0] w_r;
  logic                  w_unused;

  assign w_ext    = {{(RELU_MAX_W-BW){i_data[BW-1]}}, i_data};
  assign w_r      = relu(w_ext);
  assign w_unused = ^w_r[RELU_MAX_W-1:BW];
  assign o_relu   = w_r[BW-1:0];

  // Both operands are non-negative here, so an unsigned compare suffices.
  assign o_max = (i_pair > o_relu) ? i_pair : o_relu;

endmodule

// File: rtl/relu_maxpool_stage.sv
// Reads the Result RAM filter by filter, applies ReLU and 2:1 width
// max-pooling, and writes pooled samples to the next layer's Data RAM.
module relu_maxpool_stage
  import relu_maxpool_stage_pkg::*;
#(
  parameter int Bit_width                  = 16,
  parameter int Dataset_depth_counter_bits = 9,
  parameter int Filter_counter_bits        = 3,
  parameter int Num_filters                = 8,
  parameter int Input_length               = 512
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  Start,
  output logic                                  Result_RAM_Read_Enable,
  output logic [Filter_counter_bits-1:0]        Result_RAM_read_address_depth,
  output logic [Dataset_depth_counter_bits-1:0] Result_RAM_read_address_width,
  input  logic [Bit_width-1:0]                  Result_RAM_read_data,
  output logic                                  Out_RAM_write_M,
  output logic [Filter_counter_bits-1:0]        Out_RAM_write_address_depth,
  output logic [Dataset_depth_counter_bits-1:0] Out_RAM_write_address_width,
  output logic [Bit_width-1:0]                  Out_RAM_write_data,
  output logic                                  Busy,
  output logic                                  Done_M
);

  localparam int F = Filter_counter_bits;
  localparam int W = Dataset_depth_counter_bits;
  localparam logic [F-1:0] LAST_D = F'(Num_filters - 1);
  localparam logic [W-1:0] LAST_W = W'(Input_length - 1);

  state_t r_state;
  state_t w_next;

  logic           r_rd_en;
  logic [F-1:0]   r_rd_d;
  logic [W-1:0]   r_rd_w;
  logic           r_tag_v;
  logic [F-1:0]   r_tag_d;
  logic [W-1:0]   r_tag_w;
  logic [Bit_width-1:0] r_pair;
  logic           r_wr;
  logic [F-1:0]   r_wr_d;
  logic [W-1:0]   r_wr_w;
  logic [Bit_width-1:0] r_wr_data;
  logic           r_busy;
  logic           r_done;

  logic           w_last;
  logic           w_wr_now;
  logic [Bit_width-1:0] w_relu;
  logic [Bit_width-1:0] w_max;

  relu_max_unit #(
    .BW(Bit_width)
  ) u_relu_max (
    .i_pair(r_pair),
    .i_data(Result_RAM_read_data),
    .o_relu(w_relu),
    .o_max (w_max)
  );

  assign w_last   = (r_rd_d == LAST_D) && (r_rd_w == LAST_W);
  assign w_wr_now = r_tag_v && r_tag_w[0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (Start) w_next = READ;
      READ:    if (w_last) w_next = DRAIN;
      DRAIN:   if (r_wr) w_next = DONE;
      DONE:    w_next = Start ? READ : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_rd_en   <= 1'b0;
      r_rd_d    <= '0;
      r_rd_w    <= '0;
      r_tag_v   <= 1'b0;
      r_tag_d   <= '0;
      r_tag_w   <= '0;
      r_pair    <= '0;
      r_wr      <= 1'b0;
      r_wr_d    <= '0;
      r_wr_w    <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_en <= (w_next == READ);
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);

      // Terminal compare on width, not counter wrap.
      if (w_next == READ && r_state != READ) begin
        r_rd_d <= '0;
        r_rd_w <= '0;
      end else if (r_state == READ && !w_last) begin
        if (r_rd_w == LAST_W) begin
          r_rd_w <= '0;
          r_rd_d <= r_rd_d + 1'b1;
        end else begin
          r_rd_w <= r_rd_w + 1'b1;
        end
      end

      r_tag_v <= r_rd_en;
      r_tag_d <= r_rd_d;
      r_tag_w <= r_rd_w;

      if (r_tag_v && !r_tag_w[0]) r_pair <= w_relu;

      r_wr <= w_wr_now;
      if (w_wr_now) begin
        r_wr_d    <= r_tag_d;
        r_wr_w    <= r_tag_w >> $clog2(POOL_FACTOR);
        r_wr_data <= w_max;
      end
    end
  end

  assign Result_RAM_Read_Enable        = r_rd_en;
  assign Result_RAM_read_address_depth = r_rd_d;
  assign Result_RAM_read_address_width = r_rd_w;
  assign Out_RAM_write_M               = r_wr;
  assign Out_RAM_write_address_depth   = r_wr_d;
  assign Out_RAM_write_address_width   = r_wr_w;
  assign Out_RAM_write_data            = r_wr_data;
  assign Busy                          = r_busy;
  assign Done_M                        = r_done;

endmodule
